// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encoding, bit-period helper, parity build switch.
// Parity support is selected by defining UART_RX_PARITY_EN.
package uart_pkg;

    localparam int ST_WAIT_HIGH = 0;
    localparam int ST_IDLE      = 1;
    localparam int ST_START     = 2;
    localparam int ST_DATA      = 3;
    localparam int ST_PARITY    = 4;
    localparam int ST_STOP      = 5;
    localparam int ST_NUM       = 6;

    localparam logic [ST_NUM-1:0] OH_WAIT_HIGH = ST_NUM'(1) << ST_WAIT_HIGH;
    localparam logic [ST_NUM-1:0] OH_IDLE      = ST_NUM'(1) << ST_IDLE;
    localparam logic [ST_NUM-1:0] OH_START     = ST_NUM'(1) << ST_START;
    localparam logic [ST_NUM-1:0] OH_DATA      = ST_NUM'(1) << ST_DATA;
    localparam logic [ST_NUM-1:0] OH_PARITY    = ST_NUM'(1) << ST_PARITY;
    localparam logic [ST_NUM-1:0] OH_STOP      = ST_NUM'(1) << ST_STOP;

    typedef enum logic [ST_NUM-1:0] {
        S_WAIT_HIGH = OH_WAIT_HIGH,
        S_IDLE      = OH_IDLE,
        S_START     = OH_START,
        S_DATA      = OH_DATA,
        S_PARITY    = OH_PARITY,
        S_STOP      = OH_STOP
    } uart_state_e;

`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Clocks per bit; callers must keep the result >= 4.
    function automatic int bit_cycles(input int clk_hz, input int baud_rate);
        return clk_hz / baud_rate;
    endfunction

endpackage

// File: rtl/uart_fsm_rx_if.sv
// Receiver-side bundle: serial line in, byte and status pulses out.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_fsm_rx_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport slave  (input  rx_in, output data_out, rx_valid, frame_err, rx_busy, parity_err);
    modport master (output rx_in, input  data_out, rx_valid, frame_err, rx_busy, parity_err);
`else
    modport slave  (input  rx_in, output data_out, rx_valid, frame_err, rx_busy);
    modport master (output rx_in, input  data_out, rx_valid, frame_err, rx_busy);
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rx line plus falling-edge detect on the synced value.
// All flops reset to 1 so an idle-high line produces no spurious edge on reset release.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rx_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s = sync_q;
    assign fall = prev_q & ~sync_q;
endmodule

// File: rtl/uart_fsm_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling with one-cycle valid/error pulses.
// Define UART_RX_PARITY_EN for 8E1 with a parity_err pulse.
module uart_fsm_rx #(
    parameter int baud        = 9_600,
    parameter int clock_speed = 16_000_000
) (
    input  logic         clk,
    input  logic         CLR_n,
    uart_fsm_rx_if.slave bus
);
    import uart_pkg::*;

    localparam int BIT_CYCLES  = bit_cycles(clock_speed, baud);
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = $clog2(BIT_CYCLES) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (CLR_n),
        .rx_in (bus.rx_in),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_WAIT_HIGH: begin
                if (rx_s) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (fall) state_d = S_START;
            end
            S_START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (cnt_q == HALF_LAST) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shreg_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        if (PARITY_EN) state_d = S_PARITY;
                        else           state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    par_d   = rx_s;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                // Leaving mid-stop-bit lets a start edge right at the stop end be caught.
                if (cnt_q == BIT_LAST) begin
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end else begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shreg_q, par_q}) begin
                            parity_err_d = 1'b1;
                        end else begin
                            data_d     = shreg_q;
                            rx_valid_d = 1'b1;
                        end
`else
                        data_d     = shreg_q;
                        rx_valid_d = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q     <= S_WAIT_HIGH;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.data_out  = data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_fsm_rx.sv
// Directed bench for uart_fsm_rx: 16 clocks per bit, frames driven on falling clock edges.
// Parity vectors run only when UART_RX_PARITY_EN is defined.
module tb_uart_fsm_rx;
    import uart_pkg::*;

    localparam int CLK_HZ = 16_000;
    localparam int BAUD   = 1_000;
    localparam int BITC   = 16;
    localparam int PERIOD = 10;
    // rx_valid seen 155 clocks after the line drops (2 sync + 1 edge + 8 half + 9x16), +16 with parity.
    localparam longint LAT = (155 + (PARITY_EN ? 16 : 0)) * PERIOD;

    logic clk = 1'b0;
    logic CLR_n;
    always #5 clk = ~clk;

    uart_fsm_rx_if bus();

    uart_fsm_rx #(.baud(BAUD), .clock_speed(CLK_HZ)) dut (
        .clk   (clk),
        .CLR_n (CLR_n),
        .bus   (bus)
    );

    int         n_chk = 0;
    int         n_err = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] got_q[$];
    longint     t_start = 0;
    longint     t_valid = 0;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            valid_cnt++;
            got_q.push_back(bus.data_out);
            t_valid = longint'($time);
        end
        if (bus.frame_err) ferr_cnt++;
        if (bus.rx_valid && bus.frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err) perr_cnt++;
        if (bus.parity_err && (bus.rx_valid || bus.frame_err)) both_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    // Called on a falling edge; holds the line for n cycles.
    task automatic drive(input logic b, input int n);
        bus.rx_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
        logic p;
        p = (^d) ^ bad_par;
        t_start = longint'($time);
        drive(1'b0, BITC);
        for (int i = 0; i < 8; i++) drive(d[i], BITC);
        if (PARITY_EN) drive(p, BITC);
        drive(stop_b, BITC);
    endtask

    initial begin
        logic [7:0] v55;
        v55 = 8'h55;
        CLR_n = 1'b0;
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data",  bus.data_out, 8'h00);
        chk("rst_valid", bus.rx_valid, 1'b0);
        chk("rst_ferr",  bus.frame_err, 1'b0);
        chk("rst_busy",  bus.rx_busy, 1'b1);
        CLR_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", bus.rx_busy, 1'b0);

        // Clean 0xA5 frame
        send_frame(8'hA5, 1'b1, 1'b0);
        drive(1'b1, 8);
        chk("a5_cnt",  valid_cnt, 1);
        chk("a5_data", bus.data_out, 8'hA5);
        chk("a5_q",    q_at(0), 8'hA5);
        chk("a5_ferr", ferr_cnt, 0);
        chk("a5_lat",  t_valid - t_start, LAT);
        chk("a5_busy", bus.rx_busy, 1'b0);

        // 5-cycle low glitch aborts in START
        drive(1'b0, 5);
        chk("gl_busy_mid", bus.rx_busy, 1'b1);
        drive(1'b1, 20);
        chk("gl_cnt",  valid_cnt, 1);
        chk("gl_ferr", ferr_cnt, 0);
        chk("gl_data", bus.data_out, 8'hA5);
        chk("gl_busy", bus.rx_busy, 1'b0);

        // Bad stop bit, line held low (break), then recovery
        send_frame(8'h3C, 1'b0, 1'b0);
        drive(1'b0, 40);
        chk("fe_ferr", ferr_cnt, 1);
        chk("fe_cnt",  valid_cnt, 1);
        chk("fe_data", bus.data_out, 8'hA5);
        chk("fe_busy_low", bus.rx_busy, 1'b1);
        drive(1'b1, 6);
        chk("fe_busy_high", bus.rx_busy, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        drive(1'b1, 8);
        chk("r81_cnt",  valid_cnt, 2);
        chk("r81_data", bus.data_out, 8'h81);

        // Back-to-back with no idle gap
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive(1'b1, 8);
        chk("b2b_cnt",  valid_cnt, 4);
        chk("b2b_q0",   q_at(2), 8'h00);
        chk("b2b_q1",   q_at(3), 8'hFF);
        chk("b2b_data", bus.data_out, 8'hFF);

        // Reset in the middle of bit 4 of 0x55
        drive(1'b0, BITC);
        for (int i = 0; i < 4; i++) drive(v55[i], BITC);
        drive(v55[4], 8);
        CLR_n = 1'b0;
        bus.rx_in = 1'b1;
        @(negedge clk);
        chk("mr_data",  bus.data_out, 8'h00);
        chk("mr_busy",  bus.rx_busy, 1'b1);
        chk("mr_valid", bus.rx_valid, 1'b0);
        repeat (2) @(negedge clk);
        CLR_n = 1'b1;
        drive(1'b1, 20);
        chk("mr_cnt",       valid_cnt, 4);
        chk("mr_ferr",      ferr_cnt, 1);
        chk("mr_busy_idle", bus.rx_busy, 1'b0);
        chk("mr_data_idle", bus.data_out, 8'h00);
        send_frame(8'h55, 1'b1, 1'b0);
        drive(1'b1, 8);
        chk("r55_cnt",  valid_cnt, 5);
        chk("r55_data", bus.data_out, 8'h55);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        drive(1'b1, 8);
        chk("par_ok_cnt",  valid_cnt, 6);
        chk("par_ok_data", bus.data_out, 8'h07);
        chk("par_ok_perr", perr_cnt, 0);
        send_frame(8'h07, 1'b1, 1'b1);
        drive(1'b1, 8);
        chk("par_bad_perr", perr_cnt, 1);
        chk("par_bad_cnt",  valid_cnt, 6);
        chk("par_bad_ferr", ferr_cnt, 1);
`endif

        chk("excl_pulses", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
